// File: rtl/rv_timer_multi_pkg.sv
// rv_timer_multi_pkg: register map, comparator stride, parameter limits and
// the CFG register layout shared by the multi-comparator timer.
package rv_timer_multi_pkg;

    // Register byte offsets
    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_CFG        = 8'h04;
    localparam logic [7:0] ADDR_TIMER_LO   = 8'h08;
    localparam logic [7:0] ADDR_TIMER_HI   = 8'h0C;
    localparam logic [7:0] ADDR_INTR_EN    = 8'h10;
    localparam logic [7:0] ADDR_INTR_STATE = 8'h14;
    localparam logic [7:0] ADDR_INTR_TEST  = 8'h18;
    localparam logic [7:0] ADDR_CMP_BASE   = 8'h20;

    // Comparator block layout: base + CMP_STRIDE * index
    localparam int         CMP_STRIDE = 16;
    localparam logic [3:0] OFF_CMP_LO = 4'h0;
    localparam logic [3:0] OFF_CMP_HI = 4'h4;
    localparam logic [3:0] OFF_PERIOD = 4'h8;

    // Legal parameter ranges
    localparam int CNT_W_MIN      = 33;
    localparam int CNT_W_MAX      = 64;
    localparam int NUM_CMP_MIN    = 1;
    localparam int NUM_CMP_MAX    = 8;
    localparam int PRESCALE_W_MAX = 16;
    localparam int STEP_W_MAX     = 16;

    // CFG register; the packed layout matches the bus word exactly
    // (step in [31:16], prescale in [15:0]).
    typedef struct packed {
        logic [STEP_W_MAX-1:0]     step;
        logic [PRESCALE_W_MAX-1:0] prescale;
    } cfg_t;

    // Mask of implemented CFG bits for the given field widths.
    function automatic logic [31:0] cfg_mask(input int prescale_w, input int step_w);
        logic [31:0] m;
        m = (((32'h1 << step_w) - 32'h1) << 16) | ((32'h1 << prescale_w) - 32'h1);
        return m;
    endfunction

endpackage

// File: rtl/rv_timer_multi_cmp.sv
// rv_timer_multi_cmp: one comparator channel. Holds the compare value, the
// optional period register (RV_TIMER_MULTI_PERIODIC_EN), the match compare,
// the auto-reload adder and the sticky interrupt state bit.
module rv_timer_multi_cmp #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] timer_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic             wr_period_i,
    input  logic [31:0]      wdata_i,
    input  logic             clr_i,
    input  logic             test_i,
    output logic [CNT_W-1:0] cmp_o,
    output logic [31:0]      period_o,
    output logic             intr_state_o
);

    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             state_q, state_d;
    logic             match;

    // Level match: stays true for as long as the timer is at or past cmp.
    assign match = (timer_i >= cmp_q);

`ifdef RV_TIMER_MULTI_PERIODIC_EN
    logic [31:0] period_q, period_d;

    // Period register is plain software storage.
    always_comb begin
        period_d = period_q;
        if (wr_period_i) period_d = wdata_i;
    end

    // Period flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) period_q <= '0;
        else       period_q <= period_d;
    end

    assign period_o = period_q;
`else
    logic unused_wr_period;
    assign unused_wr_period = wr_period_i;
    assign period_o         = '0;
`endif

    // Next compare value: reload on match, software write overrides reload.
    always_comb begin
        cmp_d = cmp_q;
`ifdef RV_TIMER_MULTI_PERIODIC_EN
        if (match) cmp_d = cmp_q + CNT_W'(period_q);
`endif
        if (wr_lo_i) cmp_d = {cmp_q[CNT_W-1:32], wdata_i};
        if (wr_hi_i) cmp_d = {wdata_i[CNT_W-33:0], cmp_q[31:0]};
    end

    // Interrupt state: W1C first, then test and hardware set, so a set wins.
    always_comb begin
        state_d = state_q;
        if (clr_i)  state_d = 1'b0;
        if (test_i) state_d = 1'b1;
        if (match)  state_d = 1'b1;
    end

    // Compare value and interrupt state flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            state_q <= state_d;
        end
    end

    assign cmp_o        = cmp_q;
    assign intr_state_o = state_q;

endmodule

// File: rtl/rv_timer_multi.sv
// rv_timer_multi: multi-comparator timer with a 32-bit request/response
// register port. Holds bus decode, prescaler and the free-running counter;
// NUM_CMP channels are instantiated from rv_timer_multi_cmp.
// Define RV_TIMER_MULTI_PERIODIC_EN to implement PERIOD registers and
// auto-reload; otherwise PERIOD decodes, reads 0 and ignores writes.
module rv_timer_multi
    import rv_timer_multi_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter int NUM_CMP    = 4,
    parameter int PRESCALE_W = 12,
    parameter int STEP_W     = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    output logic [NUM_CMP-1:0] intr_o
);

    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX || NUM_CMP < NUM_CMP_MIN ||
        NUM_CMP > NUM_CMP_MAX || PRESCALE_W > PRESCALE_W_MAX || STEP_W > STEP_W_MAX) begin : g_param_err
        $error("rv_timer_multi: parameter out of range");
    end

    localparam logic [31:0] CFG_MASK = cfg_mask(PRESCALE_W, STEP_W);

    logic                             active_q, active_d;
    cfg_t                             cfg_q, cfg_d;
    logic [PRESCALE_W-1:0]            presc_q, presc_d;
    logic [CNT_W-1:0]                 timer_q, timer_d;
    logic [NUM_CMP-1:0]               intr_en_q, intr_en_d;
    logic [NUM_CMP-1:0]               intr_state;
    logic [NUM_CMP-1:0][CNT_W-1:0]    cmp_val;
    logic [NUM_CMP-1:0][31:0]         period_val;
    logic                             rvalid_q;
    logic [31:0]                      rdata_q, rdata_d;
    logic                             err_q;
    logic                             tick;
    logic                             wr;
    logic                             hit;

    logic sel_ctrl, sel_cfg, sel_tlo, sel_thi, sel_en, sel_state, sel_test;
    logic [NUM_CMP-1:0] sel_lo, sel_hi, sel_per;
    logic unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign wr          = req_i & we_i;

    // Global register decode on word address
    assign sel_ctrl  = (addr_i[7:2] == ADDR_CTRL[7:2]);
    assign sel_cfg   = (addr_i[7:2] == ADDR_CFG[7:2]);
    assign sel_tlo   = (addr_i[7:2] == ADDR_TIMER_LO[7:2]);
    assign sel_thi   = (addr_i[7:2] == ADDR_TIMER_HI[7:2]);
    assign sel_en    = (addr_i[7:2] == ADDR_INTR_EN[7:2]);
    assign sel_state = (addr_i[7:2] == ADDR_INTR_STATE[7:2]);
    assign sel_test  = (addr_i[7:2] == ADDR_INTR_TEST[7:2]);

    assign hit = sel_ctrl | sel_cfg | sel_tlo | sel_thi | sel_en | sel_state | sel_test |
                 (|sel_lo) | (|sel_hi) | (|sel_per);

    // Prescaler tick: one cycle out of every prescale+1 while active.
    assign tick = active_q && (16'(presc_q) == cfg_q.prescale);

    // Control, config and enable registers
    always_comb begin
        active_d  = active_q;
        cfg_d     = cfg_q;
        intr_en_d = intr_en_q;
        if (wr && sel_ctrl) active_d  = wdata_i[0];
        if (wr && sel_cfg)  cfg_d     = cfg_t'(wdata_i & CFG_MASK);
        if (wr && sel_en)   intr_en_d = wdata_i[NUM_CMP-1:0];
    end

    // Prescaler and counter; a software timer write replaces that tick's increment.
    always_comb begin
        presc_d = presc_q;
        if (active_q) presc_d = tick ? '0 : presc_q + 1'b1;
        timer_d = timer_q;
        if (tick)           timer_d = timer_q + CNT_W'(cfg_q.step);
        if (wr && sel_tlo)  timer_d = {timer_q[CNT_W-1:32], wdata_i};
        if (wr && sel_thi)  timer_d = {wdata_i[CNT_W-33:0], timer_q[31:0]};
    end

    // Comparator channels
    for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
        localparam logic [7:0] CH_BASE = ADDR_CMP_BASE + 8'(CMP_STRIDE * i);
        logic ch_sel;

        assign ch_sel     = (addr_i[7:4] == CH_BASE[7:4]);
        assign sel_lo[i]  = ch_sel && (addr_i[3:2] == OFF_CMP_LO[3:2]);
        assign sel_hi[i]  = ch_sel && (addr_i[3:2] == OFF_CMP_HI[3:2]);
        assign sel_per[i] = ch_sel && (addr_i[3:2] == OFF_PERIOD[3:2]);

        rv_timer_multi_cmp #(.CNT_W(CNT_W)) u_cmp (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .timer_i      (timer_q),
            .wr_lo_i      (wr && sel_lo[i]),
            .wr_hi_i      (wr && sel_hi[i]),
            .wr_period_i  (wr && sel_per[i]),
            .wdata_i      (wdata_i),
            .clr_i        (wr && sel_state && wdata_i[i]),
            .test_i       (wr && sel_test && wdata_i[i]),
            .cmp_o        (cmp_val[i]),
            .period_o     (period_val[i]),
            .intr_state_o (intr_state[i])
        );
    end

    // Read data mux; INTR_TEST and unmapped addresses read 0.
    always_comb begin
        rdata_d = '0;
        if (sel_ctrl)  rdata_d = {31'b0, active_q};
        if (sel_cfg)   rdata_d = cfg_q;
        if (sel_tlo)   rdata_d = timer_q[31:0];
        if (sel_thi)   rdata_d = 32'(timer_q[CNT_W-1:32]);
        if (sel_en)    rdata_d = 32'(intr_en_q);
        if (sel_state) rdata_d = 32'(intr_state);
        for (int i = 0; i < NUM_CMP; i++) begin
            if (sel_lo[i])  rdata_d = cmp_val[i][31:0];
            if (sel_hi[i])  rdata_d = 32'(cmp_val[i][CNT_W-1:32]);
            if (sel_per[i]) rdata_d = period_val[i];
        end
    end

    // Register state flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            cfg_q     <= '0;
            intr_en_q <= '0;
            presc_q   <= '0;
            timer_q   <= '0;
        end else begin
            active_q  <= active_d;
            cfg_q     <= cfg_d;
            intr_en_q <= intr_en_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
        end
    end

    // Registered response: valid one cycle after every request, data only for mapped reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= (req_i && !we_i && hit) ? rdata_d : 32'h0;
            err_q    <= req_i && !hit;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign intr_o   = intr_state & intr_en_q;

endmodule

// File: tb/tb_rv_timer_multi.sv
// Directed bench for rv_timer_multi (default parameters). Inputs change on the
// falling edge; outputs are sampled on the falling edge after the capture edge.
module tb_rv_timer_multi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [3:0]  intr_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        re;
  logic        rv;

  rv_timer_multi #(.CNT_W(64), .NUM_CMP(4), .PRESCALE_W(12), .STEP_W(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .intr_o   (intr_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // driver tasks: start and end on a falling edge
  task automatic do_reset();
    req_i = 1'b0; we_i = 1'b0; addr_i = 8'h0; wdata_i = 32'h0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic e, output logic v);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = 32'h0;
    @(negedge clk_i);
    d = rdata_o; e = err_o; v = rvalid_o;
    req_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus_write(8'h04, 32'h0005_0003);
    bus_write(8'h08, 32'h0000_1234);
    bus_write(8'h0C, 32'h0000_0055);
    bus_write(8'h10, 32'h0000_000F);
    checks++; if (intr_o !== 4'hF) begin errors++; $display("FAIL pre_reset_intr: got %h expected %h", intr_o, 4'hF); end
    // read in flight when reset hits
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h04;
    #2 rst_i = 1'b1;
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL reset_intr: got %h expected 0", intr_o); end
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL reset_timer_lo: got %h/%b expected 0/1", rd, rv); end
    bus_read(8'h0C, rd, re, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_timer_hi: got %h expected 0", rd); end
    bus_read(8'h04, rd, re, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_cfg: got %h expected 0", rd); end
  endtask

  task automatic test_prescale();
    do_reset();
    bus_write(8'h04, 32'h0001_0003);
    bus_write(8'h00, 32'h1);
    repeat (39) @(negedge clk_i);
    bus_write(8'h00, 32'h0);
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL prescale_step1: got %0d expected 10", rd); end
    bus_write(8'h04, 32'h0005_0003);
    bus_write(8'h00, 32'h1);
    repeat (7) @(negedge clk_i);
    bus_write(8'h00, 32'h0);
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL prescale_step5: got %0d expected 20", rd); end
    repeat (5) @(negedge clk_i);
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL prescale_frozen: got %0d expected 20", rd); end
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_read(8'h04, rd, re, rv);
    checks++; if (rd !== 32'h00FF_0FFF) begin errors++; $display("FAIL cfg_mask: got %h expected %h", rd, 32'h00FF_0FFF); end
  endtask

  task automatic test_oneshot();
    do_reset();
    bus_write(8'h04, 32'h0001_0000);
    bus_write(8'h20, 32'd5);
    bus_write(8'h14, 32'hF);
    bus_write(8'h10, 32'h1);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL oneshot_idle: got %h expected 0", intr_o); end
    bus_write(8'h00, 32'h1);
    repeat (5) @(negedge clk_i);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL oneshot_early: got %h expected 0", intr_o); end
    @(negedge clk_i);
    checks++; if (intr_o !== 4'h1) begin errors++; $display("FAIL oneshot_rise: got %h expected 1", intr_o); end
    bus_write(8'h00, 32'h0);
    bus_write(8'h14, 32'h1);
    checks++; if (intr_o !== 4'h1) begin errors++; $display("FAIL oneshot_set_wins: got %h expected 1", intr_o); end
    bus_read(8'h14, rd, re, rv);
    checks++; if (rd !== 32'hF) begin errors++; $display("FAIL oneshot_state: got %h expected F", rd); end
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'd7) begin errors++; $display("FAIL oneshot_timer: got %0d expected 7", rd); end
    bus_read(8'h20, rd, re, rv);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL oneshot_cmp_kept: got %0d expected 5", rd); end
  endtask

  task automatic test_periodic();
    do_reset();
`ifdef RV_TIMER_MULTI_PERIODIC_EN
    bus_write(8'h04, 32'h0001_0000);
    bus_write(8'h30, 32'd10);
    bus_write(8'h38, 32'd10);
    bus_write(8'h14, 32'hF);
    bus_write(8'h10, 32'h2);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL periodic_idle: got %h expected 0", intr_o); end
    bus_write(8'h00, 32'h1);
    repeat (10) @(negedge clk_i);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL periodic_early1: got %h expected 0", intr_o); end
    @(negedge clk_i);
    checks++; if (intr_o !== 4'h2) begin errors++; $display("FAIL periodic_rise1: got %h expected 2", intr_o); end
    bus_write(8'h00, 32'h0);
    bus_write(8'h14, 32'h2);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL periodic_cleared: got %h expected 0", intr_o); end
    bus_read(8'h30, rd, re, rv);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL periodic_cmp20: got %0d expected 20", rd); end
    bus_write(8'h00, 32'h1);
    repeat (8) @(negedge clk_i);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL periodic_early2: got %h expected 0", intr_o); end
    @(negedge clk_i);
    checks++; if (intr_o !== 4'h2) begin errors++; $display("FAIL periodic_rise2: got %h expected 2", intr_o); end
    bus_write(8'h00, 32'h0);
    bus_read(8'h30, rd, re, rv);
    checks++; if (rd !== 32'd30) begin errors++; $display("FAIL periodic_cmp30: got %0d expected 30", rd); end
    bus_read(8'h38, rd, re, rv);
    checks++; if (rd !== 32'd10 || re !== 1'b0) begin errors++; $display("FAIL periodic_period: got %0d/%b expected 10/0", rd, re); end
`else
    bus_write(8'h04, 32'h0001_0000);
    bus_write(8'h30, 32'd2);
    bus_write(8'h38, 32'd3);
    bus_read(8'h38, rd, re, rv);
    checks++; if (rd !== 32'h0 || re !== 1'b0) begin errors++; $display("FAIL period_absent: got %h/%b expected 0/0", rd, re); end
    bus_write(8'h14, 32'hF);
    bus_write(8'h10, 32'h2);
    bus_write(8'h00, 32'h1);
    repeat (5) @(negedge clk_i);
    bus_write(8'h00, 32'h0);
    checks++; if (intr_o !== 4'h2) begin errors++; $display("FAIL oneshot_ch1_intr: got %h expected 2", intr_o); end
    bus_read(8'h30, rd, re, rv);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL oneshot_ch1_cmp: got %0d expected 2", rd); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    bus_write(8'h08, 32'hFFFF_FFFF);
    bus_write(8'h0C, 32'hFFFF_FFFF);
    bus_write(8'h40, 32'hFFFF_FFFF);
    bus_write(8'h44, 32'hFFFF_FFFF);
    bus_write(8'h04, 32'h0002_0000);
    bus_write(8'h10, 32'h4);
    checks++; if (intr_o !== 4'h4) begin errors++; $display("FAIL wrap_pre_match: got %h expected 4", intr_o); end
    bus_write(8'h00, 32'h1);
    bus_write(8'h00, 32'h0);
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL wrap_timer_lo: got %h expected 1", rd); end
    bus_read(8'h0C, rd, re, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_timer_hi: got %h expected 0", rd); end
    checks++; if (intr_o !== 4'h4) begin errors++; $display("FAIL wrap_sticky: got %h expected 4", intr_o); end
  endtask

  task automatic test_bus_errors();
    do_reset();
    bus_read(8'h60, rd, re, rv);
    checks++; if (re !== 1'b1 || rd !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL err_cmp_oob: got %b/%h/%b expected 1/0/1", re, rd, rv); end
    bus_read(8'h1C, rd, re, rv);
    checks++; if (re !== 1'b1) begin errors++; $display("FAIL err_1c: got %b expected 1", re); end
    bus_read(8'h2C, rd, re, rv);
    checks++; if (re !== 1'b1) begin errors++; $display("FAIL err_2c: got %b expected 1", re); end
    bus_write(8'h60, 32'h1234);
    checks++; if (err_o !== 1'b1 || rdata_o !== 32'h0) begin errors++; $display("FAIL err_write: got %b/%h expected 1/0", err_o, rdata_o); end
    bus_write(8'h08, 32'h0000_ABCD);
    checks++; if (err_o !== 1'b0 || rdata_o !== 32'h0 || rvalid_o !== 1'b1) begin errors++; $display("FAIL write_resp: got %b/%h/%b expected 0/0/1", err_o, rdata_o, rvalid_o); end
    bus_write(8'h50, 32'hFFFF_FFFF);
    bus_write(8'h54, 32'hFFFF_FFFF);
    bus_write(8'h14, 32'h8);
    bus_write(8'h10, 32'h8);
    checks++; if (intr_o !== 4'h0) begin errors++; $display("FAIL intr_test_pre: got %h expected 0", intr_o); end
    bus_write(8'h18, 32'h8);
    checks++; if (intr_o !== 4'h8) begin errors++; $display("FAIL intr_test_set: got %h expected 8", intr_o); end
    bus_read(8'h18, rd, re, rv);
    checks++; if (rd !== 32'h0 || re !== 1'b0) begin errors++; $display("FAIL intr_test_read: got %h/%b expected 0/0", rd, re); end
  endtask

  task automatic test_collision();
    do_reset();
    bus_write(8'h04, 32'h0001_0000);
    bus_write(8'h00, 32'h1);
    repeat (3) @(negedge clk_i);
    bus_write(8'h08, 32'h0000_0100);
    bus_write(8'h00, 32'h0);
    bus_read(8'h08, rd, re, rv);
    checks++; if (rd !== 32'h101) begin errors++; $display("FAIL timer_write_vs_tick: got %h expected 101", rd); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_write(8'h10, 32'h5);
    bus_read(8'h10, rd, re, rv);
    checks++; if (rd !== 32'h5 || rv !== 1'b1) begin errors++; $display("FAIL b2b_en: got %h/%b expected 5/1", rd, rv); end
    bus_write(8'h04, 32'h0003_0001);
    bus_read(8'h04, rd, re, rv);
    checks++; if (rd !== 32'h0003_0001) begin errors++; $display("FAIL b2b_cfg: got %h expected 00030001", rd); end
    bus_read(8'h00, rd, re, rv);
    checks++; if (rd !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL b2b_ctrl: got %h/%b expected 0/1", rd, rv); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_prescale();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_bus_errors();
    test_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_timer_multi.md
# rv_timer_multi

Parametrised multi-comparator timer, successor to the single-comparator RISC-V timer. It has one free-running counter of configurable width, advanced by a prescaler and step. NUM_CMP independent comparators each drive one interrupt line, in one-shot or periodic auto-reload mode. Sits on the peripheral register bus beside the interrupt controller and is accessed through a simple 32-bit request/response register port.

## Interface
- CNT_W, 64: counter and comparator width; legal range 33..64.
- NUM_CMP, 4: number of comparators / interrupt lines; legal range 1..8.
- PRESCALE_W, 12: prescaler field width.
- STEP_W, 8: step field width.
- clk_i  in  1  sole clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous assert, active-high.
- req_i  in  1  register access request, single cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  8  byte address, word aligned; bits [1:0] ignored.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle after req_i.
- rdata_o  out  32  read data, valid with rvalid_o; 0 for writes.
- err_o  out  1  unmapped address, valid with rvalid_o.
- intr_o  out  NUM_CMP  interrupt per comparator = intr_state & intr_enable.

## Operation
- Register map:
  - 0x00 CTRL: bit0 active.
  - 0x04 CFG: [PRESCALE_W-1:0] prescale; [16+STEP_W-1:16] step.
  - 0x08 TIMER_LO.
  - 0x0C TIMER_HI: bits CNT_W-1:32, zero-extended.
  - 0x10 INTR_EN.
  - 0x14 INTR_STATE: read; write-1-to-clear.
  - 0x18 INTR_TEST: write-only; reads 0; writing 1 sets the state bit.
  - Comparator i at 0x20+16*i: +0 CMP_LO, +4 CMP_HI, +8 PERIOD (32-bit).
- Prescaler:
  - Internal counter runs only while active.
  - When it equals prescale it emits a one-cycle tick and returns to 0.
  - Tick rate is one per prescale+1 cycles.
  - Clearing active freezes the prescaler and timer; neither is cleared.
- Counter: on tick, timer <= timer + step, modulo 2^CNT_W. No carry out and no overflow flag.
- Match:
  - match_i = (timer >= cmp_i), unsigned, full CNT_W width.
  - Evaluated every cycle regardless of active.
  - While match_i holds, intr_state[i] is set every cycle (level semantics).
- Periodic mode:
  - PERIOD_i != 0 selects periodic mode.
  - On a cycle with match_i, cmp_i <= cmp_i + PERIOD_i, modulo 2^CNT_W, zero-extended.
  - PERIOD_i = 0 selects one-shot: cmp_i is unchanged.
- 64-bit values are written as two non-atomic 32-bit writes; software clears active first.
- Simultaneous events:
  - Hardware set and W1C on the same bit: set wins.
  - Software write to CMP_x and periodic reload in the same cycle: software wins.
  - Software write to TIMER_x and tick in the same cycle: the written value lands and the increment for that tick is dropped.
- Unmapped address:
  - err_o = 1 and rdata_o = 0.
  - Writes have no effect.
  - Comparator offsets at index >= NUM_CMP are unmapped.

## Timing
- Reset values: rvalid_o, rdata_o, err_o, intr_o, all registers, prescaler, timer, cmp and period are all 0.
- Reset mid-access: the pending response is discarded; rvalid_o = 0 on the cycle after reset deasserts.
- Register write takes effect in flops at the clock edge ending the req_i cycle.
- Read response is registered: rvalid_o, rdata_o and err_o appear exactly one cycle after req_i. Back-to-back requests are accepted every cycle.
- Timer latency: the timer flop updates at the edge ending the tick cycle.
- Interrupt latency: intr_state[i], and therefore intr_o[i], is set one cycle after the timer flop first satisfies timer >= cmp_i. The periodic reload happens on that same edge.
- intr_o is driven directly from flops; there is no combinational path from req_i.

## Configuration
- RV_TIMER_MULTI_PERIODIC_EN defined: PERIOD registers and auto-reload are implemented as described.
- Macro undefined:
  - PERIOD registers still decode (err_o = 0), read 0 and ignore writes.
  - All comparators are one-shot.
  - No period flops or adders are synthesised.

## Structure
- Package rv_timer_multi_pkg holds:
  - address offset localparams;
  - comparator stride (16);
  - CNT_W and NUM_CMP limits;
  - packed cfg struct {prescale, step}.
- Sub-module rv_timer_multi_cmp holds one channel: cmp register, period register, match compare, reload adder and intr_state bit, with software write and W1C inputs.
- The top module instantiates NUM_CMP of them in a generate loop and holds the bus decode, prescaler and counter.

## Test plan
- Reset: assert rst_i mid-read -> all outputs 0 after reset; TIMER_LO and TIMER_HI read 0; CFG reads 0.
- Prescale: prescale=3, step=1, active for 40 cycles -> TIMER_LO = 10. Then step=5 for 8 more cycles -> TIMER_LO = 20.
- One-shot: prescale=0, step=1, CMP0=5, INTR_EN=1 -> intr_o[0] rises one cycle after the timer reads 5. A W1C while the timer is >= 5 leaves the bit at 1.
- Periodic (macro defined): CMP1=10, PERIOD1=10 -> intr_o[1] at timer 10. After W1C, low until it reasserts at timer 20; CMP1 reads 30.
- Wrap: CNT_W=64, timer = 0xFFFF_FFFF_FFFF_FFFF, step=2, one tick -> timer = 1. A comparator with CMP = 0xFFFF_FFFF_FFFF_FFFF matched before the wrap and stays set.
- Bus errors and collisions:
  - Read 0x20+16*NUM_CMP -> err_o = 1, rdata_o = 0.
  - TIMER_LO write coinciding with a tick -> written value held, no increment.
